// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES128 chain output stage.
package aes128_pkg;

  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [WORD_W-1:0] word_t;

  // Select one 32-bit word of a block; index 0 is the most significant word.
  function automatic word_t blk_word(input blk_t blk, input logic [1:0] idx);
    word_t w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes128_blk_fifo.sv
// Block FIFO: DEPTH x 128-bit slots with write/read pointers and occupancy.
// A write while full is still accepted when the head slot is freed in the
// same cycle. Exposes the next-cycle head block (with write bypass) and the
// next-cycle count so the parent can keep its outputs fully registered.
module aes128_blk_fifo
  import aes128_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [BLK_W-1:0] wr_data,
  input  logic             pop,
  output logic             ovf_evt,
  output logic [AW:0]      cnt_nxt,
  output logic [BLK_W-1:0] head_nxt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  blk_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] wp_nxt;
  logic [AW-1:0] rp_nxt;
  logic [AW:0]   cnt;
  logic          is_full;
  logic          pop_ok;
  logic          wr_en;

  // Accept/drop decision, pointer and count updates, next head selection.
  always_comb begin
    is_full = (cnt == FULL_CNT);
    pop_ok  = pop && (cnt != '0);
    wr_en   = wr_req && (!is_full || pop_ok);
    ovf_evt = wr_req && !wr_en;
    rp_nxt  = pop_ok ? rp + 1'b1 : rp;
    wp_nxt  = wr_en  ? wp + 1'b1 : wp;
    cnt_nxt = cnt;
    if (wr_en && !pop_ok) begin
      cnt_nxt = cnt + 1'b1;
    end else if (!wr_en && pop_ok) begin
      cnt_nxt = cnt - 1'b1;
    end
    // When the block being written becomes the head, take it straight from
    // the input so the registered output sees it one cycle after capture.
    head_nxt = (wr_en && (wp == rp_nxt)) ? wr_data : mem[rp_nxt];
  end

  // Block storage; contents are not reset, only the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wp] <= wr_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp_nxt;
      rp  <= rp_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/aes128_out_ser.sv
// AES128 chain output serialiser: captures each 128-bit result on START into
// a block FIFO and streams it as four 32-bit words (MS word first) on a
// valid/ready interface. All outputs are registered.
// Optional: define AES_OUT_BLKCNT_EN to add the 32-bit BLK_CNT output that
// counts blocks fully emitted since reset.
module aes128_out_ser
  import aes128_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] DIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [31:0]  DOUT,
  output logic         OUT_LAST,
  output logic         FULL,
  output logic         OVERFLOW
`ifdef AES_OUT_BLKCNT_EN
  ,
  output logic [31:0]  BLK_CNT
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]  widx_p0;
  logic [1:0]  widx_nxt;
  logic        xfer;
  logic        pop;
  logic        ovf_evt;
  logic [AW:0] cnt_nxt;
  blk_t        head_nxt;
  logic        vld_p0;
  word_t       dout_p0;
  logic        last_p0;
  logic        full_p0;
  logic        ovf_p0;

  aes128_blk_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .wr_req   (START),
    .wr_data  (DIN),
    .pop      (pop),
    .ovf_evt  (ovf_evt),
    .cnt_nxt  (cnt_nxt),
    .head_nxt (head_nxt)
  );

  // Handshake: a transfer advances the word index; the final word frees the slot.
  always_comb begin
    xfer     = vld_p0 && OUT_READY;
    pop      = xfer && (widx_p0 == 2'd3);
    widx_nxt = xfer ? widx_p0 + 2'd1 : widx_p0;
  end

  // ---- stage p0: registered output word, flags and word index ----
  // Output registers are loaded from next-cycle FIFO state so they track it exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      widx_p0 <= 2'd0;
      vld_p0  <= 1'b0;
      dout_p0 <= '0;
      last_p0 <= 1'b0;
      full_p0 <= 1'b0;
      ovf_p0  <= 1'b0;
    end else begin
      widx_p0 <= widx_nxt;
      vld_p0  <= (cnt_nxt != '0);
      dout_p0 <= (cnt_nxt != '0) ? blk_word(head_nxt, widx_nxt) : '0;
      last_p0 <= (cnt_nxt != '0) && (widx_nxt == 2'd3);
      full_p0 <= (cnt_nxt == FULL_CNT);
      if (ovf_evt) begin
        ovf_p0 <= 1'b1;
      end
    end
  end

  assign OUT_VALID = vld_p0;
  assign DOUT      = dout_p0;
  assign OUT_LAST  = last_p0;
  assign FULL      = full_p0;
  assign OVERFLOW  = ovf_p0;

`ifdef AES_OUT_BLKCNT_EN
  logic [31:0] blk_cnt_p0;

  // Count of blocks whose final word has been accepted; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blk_cnt_p0 <= '0;
    end else if (pop) begin
      blk_cnt_p0 <= blk_cnt_p0 + 32'd1;
    end
  end

  assign BLK_CNT = blk_cnt_p0;
`endif

endmodule

// File: tb/tb_aes128_out_ser.sv
// Scoreboard bench for aes128_out_ser: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every accepted word.
module tb_aes128_out_ser;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [127:0] DIN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [31:0]  DOUT;
  logic         OUT_LAST;
  logic         FULL;
  logic         OVERFLOW;
`ifdef AES_OUT_BLKCNT_EN
  logic [31:0]  BLK_CNT;
`endif

  aes128_out_ser #(.DEPTH(2), .AW(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .DIN       (DIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DOUT      (DOUT),
    .OUT_LAST  (OUT_LAST),
    .FULL      (FULL),
    .OVERFLOW  (OVERFLOW)
`ifdef AES_OUT_BLKCNT_EN
    ,
    .BLK_CNT   (BLK_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLKA = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
  localparam logic [127:0] BLKB = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
  localparam logic [127:0] BLKC = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] BLKD = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
  localparam logic [127:0] BLKE = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
  localparam logic [127:0] BLKF = 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3;

  int total = 0;
  int bad = 0;
  int exp_blk = 0;
  logic [32:0] sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted word against the scoreboard head.
  always @(negedge CLK) begin : mon
    logic [32:0] e;
`ifdef AES_OUT_BLKCNT_EN
    if (!RST) chk("blk_cnt", {96'd0, BLK_CNT}, exp_blk);
`endif
    if (!RST && OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %08h with nothing expected", DOUT);
      end else begin
        e = sb.pop_front();
        chk("word", {96'd0, DOUT}, {96'd0, e[31:0]});
        chk("last", {127'd0, OUT_LAST}, {127'd0, e[32]});
        if (e[32]) exp_blk++;
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [127:0] b, input bit kept);
    START = 1'b1;
    DIN   = b;
    if (kept) begin
      for (int i = 0; i < 4; i++) sb.push_back({(i == 3), b[127-32*i -: 32]});
    end
    tick();
    START = 1'b0;
    DIN   = 'x;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: words left=%0d required 0", sb.size());
      sb.delete();
    end
    tick();
    chk("idle_valid", OUT_VALID, 0);
  endtask

  task automatic do_reset;
    RST       = 1'b1;
    START     = 1'b0;
    OUT_READY = 1'b0;
    sb.delete();
    exp_blk = 0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; START = 1'b0; OUT_READY = 1'b0; DIN = '0;
    do_reset();
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_last", OUT_LAST, 0);
    chk("rst_full", FULL, 0);
    chk("rst_ovf", OVERFLOW, 0);

    // Single block, consumer always ready
    OUT_READY = 1'b1;
    chk("pre_valid", OUT_VALID, 0);
    send(BLK1, 1);
    chk("cap_latency", OUT_VALID, 1);
    chk("first_word", DOUT, 32'h00112233);
    drain();

    // Backpressure: output holds during a 5-cycle stall
    OUT_READY = 1'b0;
    send(BLK1, 1);
    repeat (5) begin
      chk("stall_valid", OUT_VALID, 1);
      chk("stall_dout", DOUT, 32'h00112233);
      chk("stall_last", OUT_LAST, 0);
      tick();
    end
    OUT_READY = 1'b1;
    drain();

    // Fill and overflow: C is dropped
    OUT_READY = 1'b0;
    send(BLKA, 1);
    chk("full_after_a", FULL, 0);
    send(BLKB, 1);
    chk("full_after_b", FULL, 1);
    chk("ovf_after_b", OVERFLOW, 0);
    send(BLKC, 0);
    chk("ovf_after_c", OVERFLOW, 1);
    chk("full_after_c", FULL, 1);
    OUT_READY = 1'b1;
    drain();
    chk("ovf_sticky", OVERFLOW, 1);
    chk("full_cleared", FULL, 0);
    do_reset();
    chk("ovf_reset", OVERFLOW, 0);

    // Simultaneous free and write while full
    send(BLKA, 1);
    send(BLKB, 1);
    chk("full_ab", FULL, 1);
    OUT_READY = 1'b1;
    n = 0;
    while (!OUT_LAST && n < 20) begin
      tick();
      n++;
    end
    chk("a_last_seen", OUT_LAST, 1);
    send(BLKC, 1);
    chk("ovf_simul", OVERFLOW, 0);
    chk("full_simul", FULL, 1);
    chk("b0_next", DOUT, 32'hB0B0B0B0);
    drain();

    // Reset mid-block aborts the partial block
    OUT_READY = 1'b0;
    send(BLKD, 1);
    send(BLKE, 1);
    OUT_READY = 1'b1;
    tick();
    tick();
    chk("mid_dout", DOUT, 32'hD2D2D2D2);
    RST = 1'b1;
    OUT_READY = 1'b0;
    sb.delete();
    exp_blk = 0;
    tick();
    RST = 1'b0;
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_dout", DOUT, 0);
    chk("mid_rst_last", OUT_LAST, 0);
    chk("mid_rst_full", FULL, 0);
    chk("mid_rst_ovf", OVERFLOW, 0);
    tick();
    chk("mid_rst_stays_empty", OUT_VALID, 0);
    OUT_READY = 1'b1;
    send(BLKF, 1);
    chk("restart_word0", DOUT, 32'hF0F0F0F0);
    drain();

`ifdef AES_OUT_BLKCNT_EN
    // Block counter steps once per emitted block
    do_reset();
    chk("blk_cnt_rst", {96'd0, BLK_CNT}, 0);
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(BLK1 ^ {4{k[31:0]}}, 1);
      n = 0;
      while (!OUT_LAST && n < 20) begin
        tick();
        n++;
      end
      chk("blk_cnt_before", {96'd0, BLK_CNT}, k);
      tick();
      chk("blk_cnt_step", {96'd0, BLK_CNT}, k + 1);
    end
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_out_ser.md
Name: aes128_out_ser

Overview:
- Downstream stage of the 4-core AES128 chain.
- Captures each 128-bit result on the chain's DONE pulse into a small block FIFO.
- Serialises each block as four 32-bit words on a valid/ready stream toward the host/bus interface.
- Decouples the fire-and-forget DONE pulse from a consumer that may stall.

Parameters:
- DEPTH, 2, number of 128-bit blocks buffered; power of two, minimum 2.
- AW, 1, block-pointer width; must equal log2(DEPTH).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  one-cycle pulse; connected to the chain's DONE; DIN is valid in this cycle.
- DIN  input  128  ciphertext block from the chain's DOUT.
- OUT_VALID  output  1  DOUT holds a valid word.
- OUT_READY  input  1  consumer accepts the word.
- DOUT  output  32  current output word.
- OUT_LAST  output  1  DOUT is word 3, the final word of a block.
- FULL  output  1  all DEPTH slots are occupied.
- OVERFLOW  output  1  sticky flag: a block was dropped.

Behaviour:
- Reset: when RST=1 at a clock edge, all pointers, the word index and the count go to 0. OUT_VALID=0, DOUT=0, OUT_LAST=0, FULL=0, OVERFLOW=0. Contents held in storage are discarded. Reset mid-block aborts the partial block and does not emit its remaining words.
- Storage: DEPTH x 128 array with write pointer wp, read pointer rp (both AW bits, wrap modulo DEPTH) and count cnt (AW+1 bits, 0..DEPTH).
- Capture: START=1 and the slot is free -> write DIN at wp, wp++, cnt++. A write in cycle N is visible at the output from cycle N+1, i.e. OUT_VALID can rise at N+1. Capture latency is 1 cycle.
- Word order: MS word first.
  - word 0 = DIN[127:96]
  - word 1 = DIN[95:64]
  - word 2 = DIN[63:32]
  - word 3 = DIN[31:0]
- Word index: widx is 2 bits.
- Output: registered. OUT_VALID = (cnt != 0). DOUT = slot[rp] word widx. OUT_LAST = OUT_VALID && widx == 3.
- Handshake:
  - A transfer occurs when OUT_VALID && OUT_READY.
  - On transfer with widx < 3: widx++.
  - On transfer with widx == 3: widx = 0, rp++, cnt--.
  - While OUT_VALID=1 and OUT_READY=0, DOUT and OUT_LAST hold stable.
  - OUT_VALID never drops without a transfer, except on reset.
- Back-to-back throughput is one word per cycle; there are no bubbles between blocks when the next slot is occupied.
- FULL = (cnt == DEPTH), registered.
- Simultaneous events:
  - START with the final-word transfer when full: the slot freed in the same cycle is reused. The capture succeeds and cnt is unchanged.
  - START with the final-word transfer when not full: both apply, cnt unchanged.
  - START with a non-final transfer: normal capture.
- Overflow: START=1 while cnt == DEPTH with no final-word transfer in that cycle -> the block is dropped. wp and cnt are unchanged and OVERFLOW is set. OVERFLOW is cleared only by RST.
- Empty: no transfer is possible; OUT_READY is ignored.
- Wrap: wp and rp wrap from DEPTH-1 to 0 naturally.
- An unknown/X value on DIN when START=0 must not reach DOUT.

Optional Feature:
- Macro AES_OUT_BLKCNT_EN.
- Defined:
  - Extra output port BLK_CNT, output, 32 bits: count of blocks fully emitted since reset.
  - Increments on each final-word transfer; wraps at 2^32.
  - Reset value 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package aes128_pkg:
  - block width constant 128.
  - word width constant 32.
  - words-per-block constant 4.
  - typedef for a 128-bit block.
  - typedef for a 32-bit word.
- One natural sub-module: aes128_blk_fifo, the DEPTH x 128 storage with wp/rp/cnt, full/empty, and the same-cycle free-and-write rule. The serialiser and word-index logic stays in the top.

Test Plan:
- Reset then single block:
  - stimulus: START with DIN=0x00112233_44556677_8899AABB_CCDDEEFF, OUT_READY=1.
  - response: from the next cycle, DOUT = 00112233, 44556677, 8899AABB, CCDDEEFF on consecutive cycles; OUT_LAST only on the 4th; then OUT_VALID=0.
- Backpressure:
  - stimulus: same block, OUT_READY=0 for 5 cycles, then 1.
  - response: DOUT holds 00112233 and OUT_VALID=1 throughout the stall; the 4 words then follow in order, with no duplicates or skips.
- Fill and overflow (DEPTH=2):
  - stimulus: three START pulses with blocks A, B, C, OUT_READY=0.
  - response: FULL=1 after B; OVERFLOW=1 after C. Releasing OUT_READY yields A then B (8 words) and C is never seen.
- Simultaneous free and write:
  - stimulus: FULL with A, B; START with block C in the same cycle as A's word 3 transfer.
  - response: OVERFLOW stays 0; output is A, B, C in order.
- Reset mid-block:
  - stimulus: assert RST after word 1 of a block has transferred.
  - response: the next cycle shows OUT_VALID=0, DOUT=0, FULL=0, OVERFLOW=0; the next block starts at word 0.
- AES_OUT_BLKCNT_EN defined:
  - stimulus: stream 3 blocks.
  - response: BLK_CNT reads 1, 2, 3, each update occurring in the cycle after the block's final-word transfer.
